// File: rtl/write_arbiter.sv
// Write-path arbiter: round-robin AW across masters, W bursts held to AW grant
// order by an order FIFO, round-robin B across slaves.
module write_arbiter #(
  parameter int          M               = 2,
  parameter int          S               = 2,
  parameter int          ADDR_WIDTH      = 32,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int unsigned SLICE_SIZE      = 32'h00010000,
  localparam int MW = $clog2(M),
  localparam int SW = $clog2(S),
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [M-1:0]            AW_request_f,
  input  logic [M*ADDR_WIDTH-1:0] AW_addr_f,
  output logic [M-1:0]            AW_grant_f,
  output logic [M*SW-1:0]         AW_sel_f,
  input  logic [M-1:0]            W_request_f,
  input  logic [M-1:0]            W_last_f,
  output logic [M-1:0]            W_grant_f,
  output logic [M*SW-1:0]         W_sel_f,
  input  logic [S-1:0]            B_request_f,
  input  logic [S*MW-1:0]         B_id_f,
  output logic [S-1:0]            B_grant_f,
  output logic [S*MW-1:0]         B_sel_f
);
  localparam int SH = $clog2(SLICE_SIZE);
  localparam int D  = M * MAX_OUTSTANDING;
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int LW = $clog2(D + 1);

  typedef enum logic {AW_IDLE, AW_ALLOW} aw_st_e;
  typedef enum logic {B_IDLE, B_ALLOW} b_st_e;
  typedef struct packed {
    logic [MW-1:0] mst;
    logic [SW-1:0] slv;
  } ord_t;

  logic [M-1:0][SW-1:0] aw_sel;
  logic [S-1:0][MW-1:0] b_id;
  logic                 unused_addr;

  for (genvar m = 0; m < M; m++) begin : g_dec
    assign aw_sel[m] = AW_addr_f[m*ADDR_WIDTH+SH +: SW];
  end
  assign AW_sel_f    = aw_sel;
  assign b_id        = B_id_f;
  assign B_sel_f     = B_id_f;
  assign unused_addr = ^AW_addr_f;

  // order FIFO: one {master, slave} entry per granted AW, popped by W_last
  ord_t          mem_q [D];
  logic [PW-1:0] wr_q, rd_q;
  logic [LW-1:0] lvl_q;
  ord_t          head;
  logic          full, empty, push, pop;

  aw_st_e        aw_st_q, aw_st_d;
  logic [MW-1:0] aw_ptr_q, aw_ptr_d, aw_nxt;
  logic [M-1:0]  aw_grant;
  b_st_e         b_st_q, b_st_d;
  logic [SW-1:0] b_ptr_q, b_ptr_d, b_nxt;
  logic [S-1:0]  b_grant;
  logic [M-1:0]  b_dec;
  logic [CW-1:0] cnt_q [M];
  logic [CW-1:0] cnt_d [M];

  assign head  = mem_q[rd_q];
  assign full  = (lvl_q == LW'(D));
  assign empty = (lvl_q == '0);
  assign push  = (aw_st_q == AW_ALLOW);
  assign pop   = !empty && W_request_f[head.mst] && W_last_f[head.mst];

  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= '{mst: aw_ptr_q, slv: aw_sel[aw_ptr_q]};

  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push) wr_q <= (wr_q == PW'(D-1)) ? '0 : wr_q + 1'b1;
      if (pop)  rd_q <= (rd_q == PW'(D-1)) ? '0 : rd_q + 1'b1;
      if (push && !pop)      lvl_q <= lvl_q + 1'b1;
      else if (pop && !push) lvl_q <= lvl_q - 1'b1;
    end

  // W is purely combinational off the FIFO head
  always_comb begin
    W_grant_f = '0;
    W_sel_f   = '0;
    for (int m = 0; m < M; m++) begin
      if (!empty && head.mst == MW'(m)) begin
        W_grant_f[m]          = W_request_f[m];
        W_sel_f[m*SW +: SW]   = head.slv;
      end
    end
  end

  assign aw_nxt = (aw_ptr_q == MW'(M-1)) ? '0 : aw_ptr_q + 1'b1;
  assign b_nxt  = (b_ptr_q == SW'(S-1)) ? '0 : b_ptr_q + 1'b1;

  always_comb begin
    aw_st_d  = aw_st_q;
    aw_ptr_d = aw_ptr_q;
    aw_grant = '0;
    case (aw_st_q)
      AW_IDLE:
        if (AW_request_f[aw_ptr_q] && !full && cnt_q[aw_ptr_q] < CW'(MAX_OUTSTANDING))
          aw_st_d = AW_ALLOW;
        else
          aw_ptr_d = aw_nxt;
      AW_ALLOW: begin
        aw_grant[aw_ptr_q] = 1'b1;
        aw_ptr_d           = aw_nxt;
        aw_st_d            = AW_IDLE;
      end
      default: aw_st_d = AW_IDLE;
    endcase
  end

  always_comb begin
    b_st_d  = b_st_q;
    b_ptr_d = b_ptr_q;
    b_grant = '0;
    b_dec   = '0;
    case (b_st_q)
      B_IDLE:
        if (B_request_f[b_ptr_q] && cnt_q[b_id[b_ptr_q]] != '0)
          b_st_d = B_ALLOW;
        else
          b_ptr_d = b_nxt;
      B_ALLOW: begin
        b_grant[b_ptr_q]     = 1'b1;
        b_dec[b_id[b_ptr_q]] = 1'b1;
        b_ptr_d              = b_nxt;
        b_st_d               = B_IDLE;
      end
      default: b_st_d = B_IDLE;
    endcase
  end

  // an AW grant and a B return for the same master cancel out
  always_comb begin
    for (int m = 0; m < M; m++) begin
      cnt_d[m] = cnt_q[m];
      if (aw_grant[m] && !b_dec[m])      cnt_d[m] = cnt_q[m] + 1'b1;
      else if (b_dec[m] && !aw_grant[m]) cnt_d[m] = cnt_q[m] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      aw_st_q  <= AW_IDLE;
      aw_ptr_q <= '0;
      b_st_q   <= B_IDLE;
      b_ptr_q  <= '0;
      for (int m = 0; m < M; m++) cnt_q[m] <= '0;
    end else begin
      aw_st_q  <= aw_st_d;
      aw_ptr_q <= aw_ptr_d;
      b_st_q   <= b_st_d;
      b_ptr_q  <= b_ptr_d;
      for (int m = 0; m < M; m++) cnt_q[m] <= cnt_d[m];
    end

  assign AW_grant_f = aw_grant;
  assign B_grant_f  = b_grant;

endmodule

// File: tb/tb_write_arbiter.sv
// Bench for write_arbiter: directed scenarios with fixed expectations plus a
// randomized run checked against a queue/counter model of the arbitration rules.
module tb_write_arbiter;
  localparam int M = 2, S = 2, AW = 32, MAXO = 2, D = M * MAXO;
  localparam int MW = 1, SW = 1;
  localparam int unsigned SLICE = 32'h00010000;

  typedef struct { int mst; int slv; } ent_t;

  logic            clk = 1'b0;
  logic            clr;
  logic [M-1:0]    aw_req, aw_grant, w_req, w_last, w_grant;
  logic [M*AW-1:0] aw_addr;
  logic [M*SW-1:0] aw_sel, w_sel;
  logic [S-1:0]    b_req, b_grant;
  logic [S*MW-1:0] b_id, b_sel;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  write_arbiter #(.M(M), .S(S), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO),
                  .SLICE_SIZE(SLICE)) dut (
    .clk(clk), .clr(clr),
    .AW_request_f(aw_req), .AW_addr_f(aw_addr), .AW_grant_f(aw_grant), .AW_sel_f(aw_sel),
    .W_request_f(w_req), .W_last_f(w_last), .W_grant_f(w_grant), .W_sel_f(w_sel),
    .B_request_f(b_req), .B_id_f(b_id), .B_grant_f(b_grant), .B_sel_f(b_sel)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    aw_req = '0; aw_addr = '0; w_req = '0; w_last = '0; b_req = '0; b_id = '0;
  endtask

  // leaves the bench at cycle 0: reset released, no edge seen yet
  task automatic do_reset();
    clr = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    clr = 1'b1;
  endtask

  task automatic test_reset();
    logic [M-1:0] exp_g;
    clr = 1'b0;
    aw_req = '1; w_req = '1; w_last = '1; b_req = '1; b_id = 2'b10;
    aw_addr[0 +: AW] = 32'h0001_0004;
    aw_addr[AW +: AW] = 32'h0000_0000;
    cyc(); cyc(); cyc();
    #1;
    checks++; if (aw_grant !== 2'b00) begin errors++; $display("FAIL rst_aw_grant: got %b, expected 00", aw_grant); end
    checks++; if (w_grant !== 2'b00) begin errors++; $display("FAIL rst_w_grant: got %b, expected 00", w_grant); end
    checks++; if (b_grant !== 2'b00) begin errors++; $display("FAIL rst_b_grant: got %b, expected 00", b_grant); end
    checks++; if (w_sel !== 2'b00) begin errors++; $display("FAIL rst_w_sel: got %b, expected 00", w_sel); end
    checks++; if (b_sel !== 2'b10) begin errors++; $display("FAIL rst_b_sel: got %b, expected 10", b_sel); end
    checks++; if (aw_sel !== 2'b01) begin errors++; $display("FAIL rst_aw_sel: got %b, expected 01", aw_sel); end
    w_req = '0; b_req = '0;
    clr = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      exp_g = (k == 1) ? 2'b01 : (k == 3) ? 2'b10 : 2'b00;
      checks++;
      if (aw_grant !== exp_g) begin errors++; $display("FAIL rst_release_c%0d: got %b, expected %b", k, aw_grant, exp_g); end
    end
    idle_inputs();
  endtask

  task automatic test_aw_rr();
    logic [M-1:0] exp_g;
    do_reset();
    aw_addr[0 +: AW] = 32'h0001_0004;
    aw_addr[AW +: AW] = 32'h0000_0000;
    aw_req = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      exp_g = (k == 1 || k == 5) ? 2'b01 : (k == 3) ? 2'b10 : 2'b00;
      checks++;
      if (aw_grant !== exp_g) begin errors++; $display("FAIL aw_rr_c%0d: got %b, expected %b", k, aw_grant, exp_g); end
    end
    checks++; if (aw_sel !== 2'b01) begin errors++; $display("FAIL aw_rr_sel: got %b, expected 01", aw_sel); end
    idle_inputs();
  endtask

  task automatic test_w_order();
    bit found;
    do_reset();
    aw_addr[0 +: AW] = 32'h0001_0000;
    aw_addr[AW +: AW] = 32'h0000_0000;
    aw_req = 2'b10;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin cyc(); if (aw_grant[1]) found = 1'b1; end
    checks++; if (!found) begin errors++; $display("FAIL w_ord_aw_m1: got no grant, expected grant within 8 cycles"); end
    aw_req = 2'b01;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin cyc(); if (aw_grant[0]) found = 1'b1; end
    checks++; if (!found) begin errors++; $display("FAIL w_ord_aw_m0: got no grant, expected grant within 8 cycles"); end
    aw_req = '0;
    w_req = 2'b01; w_last = 2'b01;
    #1;
    checks++; if (w_grant !== 2'b00) begin errors++; $display("FAIL w_ord_hold: got %b, expected 00", w_grant); end
    for (int b = 0; b < 4; b++) begin
      w_req[1] = 1'b1;
      w_last[1] = (b == 3);
      #1;
      checks++; if (w_grant !== 2'b10) begin errors++; $display("FAIL w_ord_beat%0d_grant: got %b, expected 10", b, w_grant); end
      checks++; if (w_sel !== 2'b00) begin errors++; $display("FAIL w_ord_beat%0d_sel: got %b, expected 00", b, w_sel); end
      cyc();
    end
    w_req[1] = 1'b0; w_last[1] = 1'b0;
    #1;
    checks++; if (w_grant !== 2'b01) begin errors++; $display("FAIL w_ord_m0_grant: got %b, expected 01", w_grant); end
    checks++; if (w_sel !== 2'b01) begin errors++; $display("FAIL w_ord_m0_sel: got %b, expected 01", w_sel); end
    cyc();
    checks++; if ({w_grant, w_sel} !== 4'b0000) begin errors++; $display("FAIL w_ord_drained: got %b, expected 0000", {w_grant, w_sel}); end
    idle_inputs();
  endtask

  task automatic test_outstanding();
    int n;
    bit found, early;
    do_reset();
    aw_req = 2'b01;
    n = 0;
    for (int k = 0; k < 12; k++) begin cyc(); if (aw_grant[0]) n++; end
    checks++; if (n != 2) begin errors++; $display("FAIL cap_grants: got %0d, expected 2", n); end
    b_id = 2'b00; b_req = 2'b01;
    found = 1'b0; early = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      cyc();
      if (aw_grant[0]) early = 1'b1;
      if (b_grant[0]) found = 1'b1;
    end
    checks++; if (!found || early) begin errors++; $display("FAIL cap_b_release: got b=%0b early_aw=%0b, expected b=1 early_aw=0", found, early); end
    b_req = '0;
    found = 1'b0;
    for (int k = 0; k < 2*M && !found; k++) begin cyc(); if (aw_grant[0]) found = 1'b1; end
    checks++; if (!found) begin errors++; $display("FAIL cap_aw_after_b: got no grant, expected grant within %0d cycles", 2*M); end
    idle_inputs();
  endtask

  task automatic test_simul();
    int n;
    do_reset();
    aw_req = 2'b01;
    cyc();
    checks++; if (aw_grant !== 2'b01) begin errors++; $display("FAIL sim_first_aw: got %b, expected 01", aw_grant); end
    aw_req = '0;
    cyc(); cyc();
    // cycle 3: AW pointer on M0, B pointer on S1
    aw_req = 2'b01; b_req = 2'b10; b_id = 2'b00;
    cyc();
    checks++; if ({aw_grant, b_grant} !== 4'b0110) begin errors++; $display("FAIL sim_same_cycle: got aw=%b b=%b, expected aw=01 b=10", aw_grant, b_grant); end
    b_req = '0;
    n = 0;
    for (int k = 0; k < 12; k++) begin cyc(); if (aw_grant[0]) n++; end
    checks++; if (n != 1) begin errors++; $display("FAIL sim_cnt_kept: got %0d further grants, expected 1", n); end
    idle_inputs();
  endtask

  task automatic test_spurious();
    int g0, g1;
    do_reset();
    aw_req = 2'b01;
    cyc();
    aw_req = '0;
    b_req = 2'b11; b_id = 2'b10;
    #1;
    checks++; if (b_sel !== 2'b10) begin errors++; $display("FAIL spur_b_sel: got %b, expected 10", b_sel); end
    g0 = 0; g1 = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (b_grant[0]) g0++;
      if (b_grant[1]) g1++;
    end
    checks++; if (g1 != 0) begin errors++; $display("FAIL spur_s1: got %0d grants, expected 0", g1); end
    checks++; if (g0 != 1) begin errors++; $display("FAIL spur_s0: got %0d grants, expected 1", g0); end
    idle_inputs();
  endtask

  task automatic test_random();
    int cnt_m[M];
    int stuck[S];
    ent_t q[$];
    int cand[$];
    int id, hm, tot_aw, tot_b;
    bit ok;
    logic [M-1:0] p_awr, p_awg, e_wg;
    logic [M*SW-1:0] e_sel, e_ws;
    logic [S-1:0] p_br, p_bg;
    do_reset();
    p_awr = '0; p_awg = '0; p_br = '0; p_bg = '0; tot_aw = 0; tot_b = 0;
    for (int m = 0; m < M; m++) cnt_m[m] = 0;
    for (int s = 0; s < S; s++) stuck[s] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int m = 0; m < M; m++) begin
        aw_req[m] = ($urandom_range(0, 3) != 0);
        aw_addr[m*AW +: AW] = $urandom;
        w_req[m] = ($urandom_range(0, 1) == 1);
        w_last[m] = ($urandom_range(0, 2) == 0);
      end
      // a slave holds B_id steady from assertion until it has been low a cycle
      for (int s = 0; s < S; s++) begin
        if (b_req[s]) begin
          stuck[s]++;
          if (p_bg[s] || stuck[s] > 12) b_req[s] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          id = -1;
          cand.delete();
          for (int m = 0; m < M; m++) if (cnt_m[m] > 0) cand.push_back(m);
          if ($urandom_range(0, 7) == 0) id = $urandom_range(0, M-1);
          else if (cand.size() > 0) id = cand[$urandom_range(0, cand.size()-1)];
          if (id >= 0) begin
            b_req[s] = 1'b1;
            b_id[s*MW +: MW] = MW'(id);
            stuck[s] = 0;
          end
        end
      end
      #1;
      for (int m = 0; m < M; m++) e_sel[m*SW +: SW] = SW'((aw_addr[m*AW +: AW] / SLICE) % S);
      hm = (q.size() > 0) ? q[0].mst : -1;
      for (int m = 0; m < M; m++) begin
        e_wg[m] = (hm == m) && w_req[m];
        e_ws[m*SW +: SW] = (hm == m) ? SW'(q[0].slv) : '0;
      end
      checks++; if (aw_sel !== e_sel) begin errors++; $display("FAIL rnd_aw_sel c%0d: got %b, expected %b", c, aw_sel, e_sel); end
      checks++; if (b_sel !== b_id) begin errors++; $display("FAIL rnd_b_sel c%0d: got %b, expected %b", c, b_sel, b_id); end
      checks++; if (w_grant !== e_wg) begin errors++; $display("FAIL rnd_w_grant c%0d: got %b, expected %b", c, w_grant, e_wg); end
      checks++; if (w_sel !== e_ws) begin errors++; $display("FAIL rnd_w_sel c%0d: got %b, expected %b", c, w_sel, e_ws); end
      ok = ($countones(aw_grant) <= 1) && !(|aw_grant && |p_awg);
      for (int m = 0; m < M; m++)
        if (aw_grant[m]) ok = ok && p_awr[m] && (cnt_m[m] < MAXO) && (q.size() < D);
      checks++; if (!ok) begin errors++; $display("FAIL rnd_aw_grant c%0d: got %b, expected legal grant (prev_req=%b cnt=%0d/%0d lvl=%0d)", c, aw_grant, p_awr, cnt_m[0], cnt_m[1], q.size()); end
      ok = ($countones(b_grant) <= 1) && !(|b_grant && |p_bg);
      for (int s = 0; s < S; s++)
        if (b_grant[s]) ok = ok && p_br[s] && (cnt_m[int'(b_id[s*MW +: MW])] > 0);
      checks++; if (!ok) begin errors++; $display("FAIL rnd_b_grant c%0d: got %b, expected legal grant (prev_req=%b id=%b cnt=%0d/%0d)", c, b_grant, p_br, b_id, cnt_m[0], cnt_m[1]); end
      if (hm >= 0 && w_req[hm] && w_last[hm]) void'(q.pop_front());
      for (int m = 0; m < M; m++)
        if (aw_grant[m]) begin
          q.push_back('{mst: m, slv: int'(e_sel[m*SW +: SW])});
          cnt_m[m]++;
          tot_aw++;
        end
      for (int s = 0; s < S; s++)
        if (b_grant[s]) begin
          cnt_m[int'(b_id[s*MW +: MW])]--;
          tot_b++;
        end
      p_awr = aw_req; p_awg = aw_grant; p_br = b_req; p_bg = b_grant;
      cyc();
    end
    checks++; if (tot_aw < 100) begin errors++; $display("FAIL rnd_aw_progress: got %0d grants, expected at least 100", tot_aw); end
    checks++; if (tot_b < 50) begin errors++; $display("FAIL rnd_b_progress: got %0d grants, expected at least 50", tot_b); end
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clr = 1'b0;
    idle_inputs();
    test_reset();
    test_aw_rr();
    test_w_order();
    test_outstanding();
    test_simul();
    test_spurious();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
